// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - multi-channel serial DAC transmitter with shared SCLK/SYNC
// Frames {2'b00, pd, sample} MSB first; one-deep pending buffer allows back-to-back frames.
module dac_serial_tx #(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int CLKDIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NCH*DW-1:0]   din,
  input  logic [1:0]          pd,
  output logic [NCH-1:0]      SDATA,
  output logic                SCLK,
  output logic                SYNC,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int FRAME = DW + 4;
  localparam int CW    = $clog2(2 * CLKDIV) + 1;
  localparam int BW    = $clog2(FRAME) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t                     state, state_nx;
  logic [CW-1:0]              cnt;
  logic [BW-1:0]              bit_cnt;
  logic                       sclk_r;
  logic [NCH-1:0][FRAME-1:0]  sh;
  logic                       pend_valid;
  logic [NCH*DW-1:0]          pend_din;
  logic [1:0]                 pend_pd;
  logic                       done_r;
  logic                       ovf_r;

  logic div_wrap, last_rise, gap_end, load_new, load_pend, buf_req;

  assign div_wrap  = (state == S_SHIFT) && (cnt == DIV_LAST);
  // The final rising SCLK edge closes the frame and raises SYNC in the same cycle.
  assign last_rise = div_wrap && !sclk_r && (bit_cnt == BIT_LAST);
  assign gap_end   = (state == S_GAP) && (cnt == GAP_LAST);
  assign load_pend = gap_end && pend_valid;
  assign load_new  = start && ((state == S_IDLE) || (gap_end && !pend_valid));
  assign buf_req   = start && (state != S_IDLE) && !(gap_end && !pend_valid);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SHIFT;
      S_SHIFT: if (last_rise) state_nx = S_GAP;
      S_GAP:   if (gap_end) state_nx = (pend_valid || start) ? S_SHIFT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    SYNC  = (state != S_SHIFT);
    SCLK  = sclk_r;
    busy  = (state != S_IDLE);
    done  = done_r;
    ovf   = ovf_r;
    SDATA = '0;
    if (state == S_SHIFT) begin
      for (int k = 0; k < NCH; k++) SDATA[k] = sh[k][FRAME-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      sclk_r     <= 1'b1;
      sh         <= '0;
      pend_valid <= 1'b0;
      pend_din   <= '0;
      pend_pd    <= '0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      done_r <= last_rise;
      ovf_r  <= buf_req && pend_valid;

      if (load_new || load_pend) begin
        cnt     <= '0;
        bit_cnt <= '0;
        sclk_r  <= 1'b1;
        for (int k = 0; k < NCH; k++) begin
          sh[k] <= load_pend ? {2'b00, pend_pd, pend_din[k*DW +: DW]}
                             : {2'b00, pd, din[k*DW +: DW]};
        end
      end else if (state == S_SHIFT) begin
        if (div_wrap) begin
          cnt    <= '0;
          sclk_r <= !sclk_r;
          // Data only advances on the rising SCLK edge so it is stable across the fall.
          if (!sclk_r) begin
            bit_cnt <= bit_cnt + 1'b1;
            for (int k = 0; k < NCH; k++) sh[k] <= {sh[k][FRAME-2:0], 1'b0};
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (state == S_GAP) begin
        cnt <= gap_end ? '0 : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (load_pend) begin
        pend_valid <= 1'b0;
      end else if (buf_req && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_din   <= din;
        pend_pd    <= pd;
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - self-checking bench for dac_serial_tx
// Two instances: default (NCH=2, CLKDIV=2) and NCH=1, CLKDIV=1.
module tb_dac_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start;
  logic [23:0] a_din;
  logic [1:0]  a_pd;
  logic [1:0]  a_sdata;
  logic        a_sclk, a_sync, a_busy, a_done, a_ovf;

  logic        b_rst, b_start;
  logic [11:0] b_din;
  logic [1:0]  b_pd;
  logic [0:0]  b_sdata;
  logic        b_sclk, b_sync, b_busy, b_done, b_ovf;

  dac_serial_tx #(.NCH(2), .DW(12), .CLKDIV(2)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .din(a_din), .pd(a_pd),
    .SDATA(a_sdata), .SCLK(a_sclk), .SYNC(a_sync), .busy(a_busy), .done(a_done), .ovf(a_ovf)
  );

  dac_serial_tx #(.NCH(1), .DW(12), .CLKDIV(1)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .din(b_din), .pd(b_pd),
    .SDATA(b_sdata), .SCLK(b_sclk), .SYNC(b_sync), .busy(b_busy), .done(b_done), .ovf(b_ovf)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [1:0] p, input logic [11:0] d);
    return {2'b00, p, d};
  endfunction

  // Monitor: collects bits on every SCLK fall while SYNC is low, one record per SYNC-low window.
  typedef struct {
    logic [15:0] ch0;
    logic [15:0] ch1;
    int          nbits;
    int          low;
    logic        done_ok;
  } frame_t;

  frame_t      got_a[$];
  frame_t      got_b[$];
  logic        p_sclk [2] = '{1'b1, 1'b1};
  logic        p_sync [2] = '{1'b1, 1'b1};
  logic [15:0] acc0 [2]   = '{16'h0, 16'h0};
  logic [15:0] acc1 [2]   = '{16'h0, 16'h0};
  int          nb [2]     = '{0, 0};
  int          lc [2]     = '{0, 0};
  logic        pa_done = 1'b0, pa_ovf = 1'b0, pb_done = 1'b0;

  always @(negedge clk) begin : mon
    logic   s_sclk, s_sync, s_d0, s_d1, s_done;
    frame_t f;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        s_sclk = a_sclk; s_sync = a_sync; s_d0 = a_sdata[0]; s_d1 = a_sdata[1]; s_done = a_done;
      end else begin
        s_sclk = b_sclk; s_sync = b_sync; s_d0 = b_sdata[0]; s_d1 = 1'b0; s_done = b_done;
      end
      if (s_sync === 1'b0) begin
        lc[i]++;
        if (p_sclk[i] === 1'b1 && s_sclk === 1'b0) begin
          acc0[i] = {acc0[i][14:0], s_d0};
          acc1[i] = {acc1[i][14:0], s_d1};
          nb[i]++;
        end
      end
      if (p_sync[i] === 1'b0 && s_sync === 1'b1) begin
        f.ch0 = acc0[i]; f.ch1 = acc1[i]; f.nbits = nb[i]; f.low = lc[i]; f.done_ok = s_done;
        if (i == 0) got_a.push_back(f);
        else        got_b.push_back(f);
        acc0[i] = '0; acc1[i] = '0; nb[i] = 0; lc[i] = 0;
      end
      p_sclk[i] = s_sclk;
      p_sync[i] = s_sync;
    end
    if (a_done === 1'b1) chk("a_done_single_cycle", pa_done, 1'b0);
    if (a_ovf === 1'b1)  chk("a_ovf_single_cycle", pa_ovf, 1'b0);
    if (b_done === 1'b1) chk("b_done_single_cycle", pb_done, 1'b0);
    pa_done = a_done; pa_ovf = a_ovf; pb_done = b_done;
  end

  task automatic start_a(input logic [23:0] d, input logic [1:0] p);
    a_din = d; a_pd = p; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (a_busy === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("a_idle_timeout", k < 400, 1'b1);
    @(negedge clk);
  endtask

  task automatic chk_frame(input string tag, input frame_t f, input logic [15:0] e0,
                           input logic [15:0] e1, input int elow, input bit two_ch);
    chk({tag, "_nbits"}, f.nbits, 16);
    chk({tag, "_low"}, f.low, elow);
    chk({tag, "_done"}, f.done_ok, 1'b1);
    chk({tag, "_ch0"}, f.ch0, e0);
    if (two_ch) chk({tag, "_ch1"}, f.ch1, e1);
  endtask

  task automatic pop_a(input string tag, input logic [23:0] d, input logic [1:0] p);
    frame_t f;
    chk({tag, "_present"}, got_a.size() > 0, 1'b1);
    if (got_a.size() > 0) begin
      f = got_a.pop_front();
      chk_frame(tag, f, frame_of(p, d[11:0]), frame_of(p, d[23:12]), 64, 1'b1);
    end
  endtask

  initial begin
    logic [23:0] d, d2, d3;
    logic [1:0]  p, p2;
    logic [11:0] bd1, bd2;
    logic [1:0]  bp1, bp2;
    int low_cnt, busy_cnt, done_cyc, busy_falls, sync_falls, gap_cnt, falls, tog;
    logic prev_busy, prev_sync, prev_sclk;
    frame_t f;

    a_rst = 1'b0; a_start = 1'b0; a_din = '0; a_pd = '0;
    b_rst = 1'b0; b_start = 1'b0; b_din = '0; b_pd = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_sync", a_sync, 1'b1);
    chk("rst_a_sclk", a_sclk, 1'b1);
    chk("rst_a_sdata", a_sdata, 2'b00);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_a_done", a_done, 1'b0);
    chk("rst_a_ovf", a_ovf, 1'b0);
    chk("rst_b_sync", b_sync, 1'b1);
    chk("rst_b_busy", b_busy, 1'b0);
    a_rst = 1'b1; b_rst = 1'b1;
    @(negedge clk);

    // Basic frame with the reference vectors and full timing profile
    start_a({12'h3F0, 12'hA5C}, 2'b00);
    low_cnt = 0; busy_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      if (a_sync === 1'b0) low_cnt++;
      if (a_busy === 1'b1) busy_cnt++;
      if (a_done === 1'b1) done_cyc = c;
      if (c == 1) begin
        chk("first_bit_sclk", a_sclk, 1'b1);
        chk("first_bit_sync", a_sync, 1'b0);
        a_din = $urandom; a_pd = 2'($urandom);
      end
      @(negedge clk);
    end
    chk("basic_sync_low", low_cnt, 64);
    chk("basic_done_cycle", done_cyc, 65);
    chk("basic_busy_len", busy_cnt, 68);
    chk("basic_ch0_literal", (got_a.size() > 0) ? got_a[0].ch0 : 16'hxxxx, 16'b0000_1010_0101_1100);
    chk("basic_ch1_literal", (got_a.size() > 0) ? got_a[0].ch1 : 16'hxxxx, 16'b0000_0011_1111_0000);
    pop_a("basic", {12'h3F0, 12'hA5C}, 2'b00);

    // Power-down bits only
    start_a(24'h0, 2'b11);
    wait_idle_a();
    pop_a("pd11", 24'h0, 2'b11);

    for (int r = 0; r < 3; r++) begin
      d = 24'($urandom); p = 2'($urandom);
      start_a(d, p);
      wait_idle_a();
      pop_a("rand", d, p);
    end

    // Pending request mid-frame, then overflow while the pending slot is full
    d = 24'($urandom); p = 2'($urandom);
    d2 = {12'($urandom), 12'h001}; p2 = 2'($urandom);
    d3 = 24'($urandom);
    start_a(d, p);
    busy_cnt = 0; busy_falls = 0; sync_falls = 0; gap_cnt = 0;
    prev_busy = 1'b1; prev_sync = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      if (a_busy === 1'b1) busy_cnt++;
      if (prev_busy === 1'b1 && a_busy === 1'b0) busy_falls++;
      if (prev_sync === 1'b1 && a_sync === 1'b0) sync_falls++;
      if (a_busy === 1'b1 && a_sync === 1'b1) gap_cnt++;
      prev_busy = a_busy; prev_sync = a_sync;
      if (c == 1)  begin a_din = 24'($urandom); a_pd = 2'($urandom); end
      if (c == 20) begin a_din = d2; a_pd = p2; a_start = 1'b1; end
      if (c == 21) begin a_start = 1'b0; chk("pend_no_ovf", a_ovf, 1'b0); a_din = 24'($urandom); end
      if (c == 25) begin a_din = d3; a_start = 1'b1; end
      if (c == 26) begin a_start = 1'b0; chk("ovf_pulse", a_ovf, 1'b1); end
      if (c == 27) chk("ovf_cleared", a_ovf, 1'b0);
      @(negedge clk);
    end
    chk("pend_busy_len", busy_cnt, 136);
    chk("pend_busy_falls", busy_falls, 1);
    chk("pend_sync_falls", sync_falls, 1);
    chk("pend_gap_cycles", gap_cnt, 8);
    chk("pend_frame_count", got_a.size(), 2);
    pop_a("pend_first", d, p);
    chk("pend_last_bit", (got_a.size() > 0) ? got_a[0].ch0[0] : 1'bx, 1'b1);
    pop_a("pend_second", d2, p2);

    // Reset at the 5th SCLK fall, with start held during reset
    start_a(24'($urandom), 2'($urandom));
    falls = 0; prev_sclk = 1'b1;
    for (int c = 0; c < 100 && falls < 5; c++) begin
      if (prev_sclk === 1'b1 && a_sclk === 1'b0) falls++;
      prev_sclk = a_sclk;
      if (falls < 5) @(negedge clk);
    end
    chk("rst_mid_reached", falls, 5);
    a_rst = 1'b0; a_start = 1'b1;
    @(negedge clk);
    chk("rst_mid_sync", a_sync, 1'b1);
    chk("rst_mid_sclk", a_sclk, 1'b1);
    chk("rst_mid_sdata", a_sdata, 2'b00);
    chk("rst_mid_busy", a_busy, 1'b0);
    @(negedge clk);
    chk("rst_start_ignored", a_busy, 1'b0);
    a_rst = 1'b1; a_start = 1'b0;
    @(negedge clk);
    chk("rst_release_idle", a_busy, 1'b0);
    got_a.delete();
    d = 24'($urandom); p = 2'($urandom);
    start_a(d, p);
    wait_idle_a();
    pop_a("after_rst", d, p);

    // NCH=1, CLKDIV=1; second start lands exactly on the GAP exit cycle
    bd1 = 12'($urandom); bp1 = 2'($urandom);
    bd2 = 12'($urandom); bp2 = 2'($urandom);
    b_din = bd1; b_pd = bp1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    busy_cnt = 0; busy_falls = 0; tog = 0;
    prev_busy = 1'b1; prev_sync = 1'b0; prev_sclk = 1'b1;
    for (int c = 1; c <= 90; c++) begin
      if (b_busy === 1'b1) busy_cnt++;
      if (prev_busy === 1'b1 && b_busy === 1'b0) busy_falls++;
      if (prev_sync === 1'b0 && b_sync === 1'b0 && prev_sclk !== b_sclk) tog++;
      prev_busy = b_busy; prev_sync = b_sync; prev_sclk = b_sclk;
      if (c == 34) begin b_din = bd2; b_pd = bp2; b_start = 1'b1; end
      if (c == 35) begin b_start = 1'b0; chk("b_gap_exit_no_ovf", b_ovf, 1'b0); end
      @(negedge clk);
    end
    chk("b_busy_len", busy_cnt, 68);
    chk("b_busy_falls", busy_falls, 1);
    chk("b_sclk_toggles", tog, 62);
    chk("b_frame_count", got_b.size(), 2);
    if (got_b.size() > 0) begin
      f = got_b.pop_front();
      chk_frame("b_first", f, frame_of(bp1, bd1), 16'h0, 32, 1'b0);
    end
    if (got_b.size() > 0) begin
      f = got_b.pop_front();
      chk_frame("b_second", f, frame_of(bp2, bd2), 16'h0, 32, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_serial_tx.md
DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

Interface
REQ-001 Parameter NCH, default 2: number of DAC channels, each with its own serial data line and all sharing SCLK and SYNC; legal range 1..8.
REQ-002 Parameter DW, default 12: sample width per channel.
REQ-003 Parameter CLKDIV, default 2: SCLK half-period in clk cycles; legal minimum 1.
REQ-004 Derived constant FRAME = DW+4: bits per transfer.
REQ-005 clk  in  1  single system clock; all logic is clocked on the rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 start  in  1  transfer request, sampled every clk cycle.
REQ-008 din  in  NCH*DW  samples; channel k occupies din[k*DW +: DW].
REQ-009 pd  in  2  DAC power-down mode bits, common to all channels.
REQ-010 SDATA  out  NCH  serial data, one line per channel.
REQ-011 SCLK  out  1  serial clock.
REQ-012 SYNC  out  1  frame sync, active low.
REQ-013 busy  out  1  high while a frame or inter-frame gap is in progress.
REQ-014 done  out  1  one-cycle pulse when a frame completes.
REQ-015 ovf  out  1  one-cycle pulse when a request is dropped.

Function
REQ-016 Frame per channel k: {2'b00, pd, din_k}, sent MSB first.
- All channels share SCLK and SYNC.
- All channels shift bit-synchronously.
REQ-017 State machine IDLE -> SHIFT -> GAP -> IDLE; GAP goes directly to SHIFT when a request is pending.
REQ-018 IDLE outputs: SYNC=1, SCLK=1, SDATA=0, busy=0.
REQ-019 Start acceptance in IDLE:
- start=1 sampled at edge T captures din and pd into the shift registers.
- At edge T+1: SYNC=0, SCLK=1, SDATA=frame bit FRAME-1, busy=1; divider cleared.
REQ-020 SHIFT divider and SCLK:
- Divider counts 0..CLKDIV-1.
- SCLK toggles on each wrap.
REQ-021 SHIFT data timing:
- On each SCLK 1->0 transition (DAC sample edge), SDATA is held stable.
- On each SCLK 0->1 transition, the next lower bit is presented.
REQ-022 SYNC stays low for exactly FRAME*2*CLKDIV clk cycles, covering FRAME falling SCLK edges; it then rises together with the final SCLK 0->1 transition.
- In that same cycle: state enters GAP, SDATA=0, and done pulses for one cycle.
REQ-023 GAP holds SYNC=1 and SCLK=1 for 2*CLKDIV clk cycles.
- At GAP exit with no pending request, busy falls and state returns to IDLE.
- Total busy duration for one frame is (FRAME+1)*2*CLKDIV cycles.
REQ-024 start=1 while busy=1 with the pending slot empty:
- Captures din and pd into a one-deep pending buffer.
- At GAP exit, the pending frame begins exactly as in REQ-019 with no IDLE cycle, and busy stays high.
REQ-025 start=1 while busy=1 with the pending slot full:
- Request is dropped and ovf pulses one cycle.
- Existing frame and pending data are unchanged.
REQ-026 start=1 in the same cycle that GAP exits with the pending slot empty is treated as an IDLE start per REQ-019.
REQ-027 din and pd changes after capture do not affect a frame in progress.
REQ-028 done and ovf are never high for more than one consecutive cycle per event.

Reset
REQ-029 rst=0 at any rising clk edge, including mid-frame or mid-GAP, forces on the next edge:
- State IDLE, pending cleared, divider=0.
- SYNC=1, SCLK=1, SDATA=0, busy=0, done=0, ovf=0.
REQ-030 start is ignored in any cycle where rst=0; normal operation resumes on the first edge with rst=1.

Verification (NCH=2, DW=12, CLKDIV=2 unless stated)
REQ-031 Basic frame: ch0=12'hA5C, ch1=12'h3F0, pd=00, one-cycle start.
- SDATA[0] sampled at 16 SCLK falls = 0000_1010_0101_1100.
- SDATA[1] = 0000_0011_1111_0000.
- SYNC low 64 cycles; done at cycle 65 after acceptance; busy high 68 cycles.
REQ-032 pd=2'b11, din=0: both lines show bits 13..12 = 1 and all other bits 0.
REQ-033 Pending request:
- Second start issued mid-frame with ch0=12'h001.
- After the 4-cycle GAP, SYNC falls again with busy continuously high.
- Last bit of the second frame on SDATA[0] = 1.
REQ-034 Overflow: third start while the pending slot is full -> ovf pulses one cycle; the third data word never appears on SDATA.
REQ-035 Reset at the 5th SCLK fall -> next edge SYNC=1, SCLK=1, SDATA=2'b00, busy=0; a new start then produces a complete, correct frame.
REQ-036 CLKDIV=1, NCH=1: SCLK toggles every clk cycle; SYNC low exactly 32 cycles; frame bits correct.
